// File: rtl/fast_sig_pkg.sv
// Shared constants and event-FSM encoding for the fast-domain signal change detector.
package fast_sig_pkg;

    localparam int FSIG_WIDTH         = 8;
    localparam int FSIG_STABLE_CYCLES = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } evt_state_e;

endpackage

// File: rtl/sig_stable_filter.sv
// Stability filter: the output only follows the input once the same value has been
// sampled STABLE_CYCLES times in a row. filt_next is the value filt_out takes on this edge.
module sig_stable_filter
    import fast_sig_pkg::*;
#(
    parameter int WIDTH         = FSIG_WIDTH,
    parameter int STABLE_CYCLES = FSIG_STABLE_CYCLES
) (
    input  logic             fast_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] signal_in,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] filt_next
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_N = CW'(STABLE_CYCLES);

    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CW-1:0]    stab_cnt_q, stab_cnt_d;
    logic [WIDTH-1:0] filt_q;

    always_comb begin
        cand_d     = signal_in;
        stab_cnt_d = stab_cnt_q;
        if (signal_in != cand_q) begin
            stab_cnt_d = CW'(1);
        end else if (stab_cnt_q != STABLE_N) begin
            stab_cnt_d = stab_cnt_q + CW'(1);
        end
        // The run length including this sample decides, so STABLE_CYCLES=1 is a plain register.
        filt_next = filt_q;
        if (stab_cnt_d == STABLE_N) begin
            filt_next = signal_in;
        end
    end

    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_q     <= '0;
            stab_cnt_q <= '0;
            filt_q     <= '0;
        end else begin
            cand_q     <= cand_d;
            stab_cnt_q <= stab_cnt_d;
            filt_q     <= filt_next;
        end
    end

    assign filt_out = filt_q;

endmodule

// File: rtl/fast_sig_change_detect.sv
// Filters the synchronized vector, emits per-bit edge pulses and queues one coalesced
// change event. Define FAST_SIG_CHG_CNT_EN to build the saturating change counter.
module fast_sig_change_detect
    import fast_sig_pkg::*;
#(
    parameter int WIDTH         = FSIG_WIDTH,
    parameter int STABLE_CYCLES = FSIG_STABLE_CYCLES,
    parameter int CNT_W         = 8
) (
    input  logic             fast_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] signal_in_fast,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_value,
    output logic [WIDTH-1:0] evt_mask,
    output logic             evt_overrun,
    output logic [CNT_W-1:0] change_cnt
);

    logic [WIDTH-1:0] filt_next;
    logic [WIDTH-1:0] chg;
    logic             chg_any;

    sig_stable_filter #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .fast_clk (fast_clk),
        .reset_n  (reset_n),
        .signal_in(signal_in_fast),
        .filt_out (filt_out),
        .filt_next(filt_next)
    );

    assign chg     = filt_next ^ filt_out;
    assign chg_any = |chg;

    logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;

    always_comb begin
        rise_d = chg & filt_next;
        fall_d = chg & ~filt_next;
    end

    // Handshake: an event transfers on an edge where evt_valid and evt_ready are both high;
    // evt_valid never drops without a transfer (except reset), and the payload only
    // changes while valid if a newer change is folded into it.
    evt_state_e       state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d, mask_q, mask_d;
    logic             ovr_q, ovr_d;
    logic             hs;

    assign hs = (state_q == ST_PEND) && evt_ready;

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        mask_d  = mask_q;
        ovr_d   = ovr_q;
        case (state_q)
            ST_IDLE: begin
                if (chg_any) begin
                    state_d = ST_PEND;
                    value_d = filt_next;
                    mask_d  = chg;
                    ovr_d   = 1'b0;
                end
            end
            ST_PEND: begin
                if (hs && chg_any) begin
                    value_d = filt_next;
                    mask_d  = chg;
                    ovr_d   = 1'b0;
                end else if (hs) begin
                    state_d = ST_IDLE;
                    mask_d  = '0;
                    ovr_d   = 1'b0;
                end else if (chg_any) begin
                    value_d = filt_next;
                    mask_d  = mask_q | chg;
                    ovr_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q  <= '0;
            fall_q  <= '0;
            state_q <= ST_IDLE;
            value_q <= '0;
            mask_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            state_q <= state_d;
            value_q <= value_d;
            mask_q  <= mask_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign evt_valid   = (state_q == ST_PEND);
    assign evt_value   = value_q;
    assign evt_mask    = mask_q;
    assign evt_overrun = ovr_q;

`ifdef FAST_SIG_CHG_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (chg_any && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign change_cnt = cnt_q;
`else
    assign change_cnt = '0;
`endif

endmodule

// File: tb/tb_fast_sig_change_detect.sv
// Randomized bench for fast_sig_change_detect against a sample-history reference model
// with an accepted-event scoreboard.
module tb_fast_sig_change_detect;

    localparam int W      = 8;
    localparam int STABLE = 2;
    localparam int CW     = 4;

    logic          fast_clk = 1'b0;
    logic          reset_n  = 1'b0;
    logic [W-1:0]  signal_in_fast = '0;
    logic          evt_ready = 1'b0;
    logic [W-1:0]  filt_out, rise_pulse, fall_pulse, evt_value, evt_mask;
    logic          evt_valid, evt_overrun;
    logic [CW-1:0] change_cnt;

    fast_sig_change_detect #(
        .WIDTH        (W),
        .STABLE_CYCLES(STABLE),
        .CNT_W        (CW)
    ) dut (
        .fast_clk      (fast_clk),
        .reset_n       (reset_n),
        .signal_in_fast(signal_in_fast),
        .filt_out      (filt_out),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_value     (evt_value),
        .evt_mask      (evt_mask),
        .evt_overrun   (evt_overrun),
        .change_cnt    (change_cnt)
    );

    // ---------------- clock / reset / timeout ----------------
    always #5 fast_clk = ~fast_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, need done)");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    logic [2*W:0]  exp_q[$];   // {overrun, mask, value} of each accepted event
    logic [W-1:0]  hist[$];
    logic [W-1:0]  m_filt, m_rise, m_fall, m_val, m_mask;
    logic          m_pend, m_ovr;
    logic [CW-1:0] m_cnt;

    always @(posedge fast_clk or negedge reset_n) begin
        logic [W-1:0] nf, chg;
        logic         all_eq;
        if (!reset_n) begin
            hist.delete();
            m_filt = '0; m_rise = '0; m_fall = '0; m_val = '0; m_mask = '0;
            m_pend = 1'b0; m_ovr = 1'b0; m_cnt = '0;
        end else begin
            hist.push_back(signal_in_fast);
            if (hist.size() > STABLE) void'(hist.pop_front());
            nf = m_filt;
            if (hist.size() == STABLE) begin
                all_eq = 1'b1;
                foreach (hist[i]) if (hist[i] != hist[0]) all_eq = 1'b0;
                if (all_eq) nf = hist[0];
            end
            chg = nf ^ m_filt;
            if (m_pend && evt_ready) begin
                exp_q.push_back({m_ovr, m_mask, m_val});
                m_pend = 1'b0; m_mask = '0; m_ovr = 1'b0;
            end
            if (chg != '0) begin
                if (m_pend) begin
                    m_mask = m_mask | chg;
                    m_ovr  = 1'b1;
                end else begin
                    m_pend = 1'b1;
                    m_mask = chg;
                    m_ovr  = 1'b0;
                end
                m_val = nf;
`ifdef FAST_SIG_CHG_CNT_EN
                if (m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
`endif
            end
            m_rise = chg & nf;
            m_fall = chg & ~nf;
            m_filt = nf;
        end
    end

    // ---------------- driver ----------------
    logic stim_done = 1'b0;

    task automatic drive(input logic [W-1:0] v, input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            signal_in_fast = v;
            evt_ready      = rdy;
            @(posedge fast_clk);
            #1;
        end
    endtask

    initial begin
        logic [W-1:0] v;
        reset_n = 1'b0;
        repeat (3) @(posedge fast_clk);
        #1 reset_n = 1'b1;
        // single change, then accept it
        drive(8'h02, 4, 1'b0);
        drive(8'h02, 1, 1'b1);
        // one-sample glitch must be rejected
        drive(8'h0e, 1, 1'b0);
        drive(8'h02, 3, 1'b0);
        // two changes coalesce while not ready, then one handshake
        drive(8'h0e, 3, 1'b0);
        drive(8'h00, 3, 1'b0);
        drive(8'h00, 1, 1'b1);
        drive(8'h00, 2, 1'b0);
        // handshake in the same cycle as a new change
        drive(8'h02, 3, 1'b0);
        drive(8'h00, 1, 1'b0);
        drive(8'h00, 1, 1'b1);
        drive(8'h00, 2, 1'b0);
        drive(8'h00, 2, 1'b1);
        // twenty separate changes to reach counter saturation
        for (int i = 0; i < 20; i++) drive((i % 2 == 0) ? 8'h01 : 8'h00, 2, 1'b1);
        // random traffic
        for (int i = 0; i < 250; i++) begin
            v = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 3));
            drive(v, $urandom_range(1, 4), ($urandom_range(0, 3) == 0));
        end
        // drain, build a pending event with mask 0e, then reset mid-cycle
        drive(8'h00, 4, 1'b1);
        drive(8'h0e, 3, 1'b0);
        @(posedge fast_clk);
        #3 reset_n = 1'b0;
        repeat (3) @(posedge fast_clk);
        #1 reset_n = 1'b1;
        drive(8'h02, 4, 1'b0);
        drive(8'h02, 3, 1'b1);
        stim_done = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h, need %0h", name, $time, act, exp);
        end
    endtask

    initial begin
        logic [2*W:0] cap, e;
        logic         have_cap;
        have_cap = 1'b0;
        forever begin
            @(negedge fast_clk or negedge reset_n);
            #1;
            if (have_cap) begin
                have_cap = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("evt_unexpected", 32'(cap), 32'h1ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_payload", 32'(cap), 32'(e));
                end
            end
            if (!reset_n) begin
                chk("reset_outputs",
                    {evt_valid, evt_overrun, filt_out, evt_mask, rise_pulse, fall_pulse[5:0]},
                    32'h0);
                chk("reset_cnt", 32'(change_cnt), 32'h0);
            end else begin
                chk("filt_out",    32'(filt_out),    32'(m_filt));
                chk("rise_pulse",  32'(rise_pulse),  32'(m_rise));
                chk("fall_pulse",  32'(fall_pulse),  32'(m_fall));
                chk("evt_valid",   32'(evt_valid),   32'(m_pend));
                chk("evt_value",   32'(evt_value),   32'(m_val));
                chk("evt_mask",    32'(evt_mask),    32'(m_mask));
                chk("evt_overrun", 32'(evt_overrun), 32'(m_ovr));
                chk("change_cnt",  32'(change_cnt),  32'(m_cnt));
                if (evt_valid && evt_ready) begin
                    cap      = {evt_overrun, evt_mask, evt_value};
                    have_cap = 1'b1;
                end
            end
            if (stim_done && !have_cap) begin
                chk("exp_q_left", 32'(exp_q.size()), 32'h0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

endmodule
